// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register carrying the write-back bundle {mem_data, alu_result, rd, control}.
// SKID=1 gives a two-entry skid buffer with a flopped in_ready; SKID=0 is a single register.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [CTRL_W-1:0] control_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [CTRL_W-1:0] control_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] control;
    } beat_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    beat_t in_beat;
    beat_t main_q;
    beat_t out_beat;
    logic  main_valid;
    logic  up;
    logic  down;

    assign in_beat = {mem_data_in, alu_result_in, rd_in, control_in};
    assign up      = in_valid & in_ready;
    assign down    = main_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            beat_t skid_q;
            logic  skid_valid;

            // in_ready comes straight from a flop, so out_ready never reaches it combinationally
            assign in_ready = !skid_valid;

            // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    main_q     <= '0;
                    skid_q     <= '0;
                end else if (flush) begin
                    // NOTE: flush only drops the valid flags; stale payload is hidden by output masking.
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (down) begin
                    if (skid_valid) begin
                        main_q     <= skid_q;
                        skid_valid <= 1'b0;
                    end else if (up) begin
                        main_q <= in_beat;
                    end else begin
                        main_valid <= 1'b0;
                    end
                end else if (up) begin
                    if (main_valid) begin
                        skid_q     <= in_beat;
                        skid_valid <= 1'b1;
                    end else begin
                        main_q     <= in_beat;
                        main_valid <= 1'b1;
                    end
                end
            end
        end else begin : g_single
            assign in_ready = !main_valid | out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_valid <= 1'b0;
                    main_q     <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (up) begin
                    main_q     <= in_beat;
                    main_valid <= 1'b1;
                end else if (down) begin
                    main_valid <= 1'b0;
                end
            end
        end
    endgenerate

    // A bubble must never present RegWrite/MemtoReg or a destination index downstream
    assign out_beat       = main_valid ? main_q : '0;
    assign out_valid      = main_valid;
    assign mem_data_out   = out_beat.mem_data;
    assign alu_result_out = out_beat.alu_result;
    assign rd_out         = out_beat.rd;
    assign control_out    = out_beat.control;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (main_valid && !out_ready && !flush && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: lane 0 is SKID=1/CNT_W=4, lane 1 is SKID=0/CNT_W=16.
// Each lane is checked against a bounded in-order queue model with a saturating stall count.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 2;
    localparam int PW = 2 * DW + RW + CW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input int lane, input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL L%0d %s: got %0h expected %0h at %0t", lane, name, act, exp, $time);
        end
    endtask

    // Ready rule stated in terms of occupancy: skid holds two beats, single register
    // accepts when empty or when its beat is leaving this cycle.
    function automatic bit exp_in_ready(input bit sk, input int occ, input bit ordy);
        return sk ? (occ < 2) : (occ == 0 || ordy);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam bit SK  = (g == 0);
        localparam int CNW = (g == 0) ? 4 : 16;
        localparam int unsigned CMAX = (1 << CNW) - 1;

        logic           rst, flush, in_valid, in_ready, out_valid, out_ready;
        logic [DW-1:0]  mem_in, alu_in, mem_out, alu_out;
        logic [RW-1:0]  rd_in, rd_out;
        logic [CW-1:0]  ctl_in, ctl_out;
        logic [CNW-1:0] stall;

        logic [PW-1:0] src[$];
        logic [PW-1:0] exp_q[$];
        int unsigned   exp_cnt = 0;
        bit            armed = 1'b0;
        bit            pop_src = 1'b0;
        bit            done = 1'b0;
        int            occ_s = 0;
        int            gap_pct = 0;

        pipe_stage_reg #(
            .DATA_W(DW), .RD_W(RW), .CTRL_W(CW), .SKID(SK ? 1 : 0), .CNT_W(CNW)
        ) dut (
            .clk(clk), .rst(rst), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready),
            .mem_data_in(mem_in), .alu_result_in(alu_in), .rd_in(rd_in), .control_in(ctl_in),
            .out_valid(out_valid), .out_ready(out_ready),
            .mem_data_out(mem_out), .alu_result_out(alu_out), .rd_out(rd_out), .control_out(ctl_out),
            .stall_cnt(stall)
        );

        // Upstream driver: presents the source head, holds it until accepted, idles with a hostile payload.
        always @(posedge clk) begin
            #2;
            if (pop_src && src.size() > 0) void'(src.pop_front());
            if (in_valid && !pop_src && src.size() > 0) begin
                in_valid = 1'b1;
            end else if (src.size() > 0 && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                {mem_in, alu_in, rd_in, ctl_in} = src[0];
            end else begin
                in_valid = 1'b0;
                mem_in   = $urandom;
                alu_in   = $urandom;
                rd_in    = '1;
                ctl_in   = '1;
            end
        end

        // Monitor: compares the presented beat with the scoreboard head and pops on a downstream transfer.
        always @(negedge clk) begin
            occ_s = exp_q.size();
            if (armed) begin
                check(g, "in_ready", in_ready, exp_in_ready(SK, occ_s, out_ready));
                check(g, "out_valid", out_valid, occ_s > 0);
                check(g, "stall_cnt", stall, exp_cnt);
                if (occ_s > 0) begin
                    check(g, "payload", {mem_out, alu_out, rd_out, ctl_out}, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end else begin
                    check(g, "bubble_mask", {mem_out, alu_out, rd_out, ctl_out}, '0);
                end
            end
        end

        // Reference model update: accepted beats join the queue, flush/reset empty it.
        always @(negedge clk) begin
            #1;
            pop_src = in_valid && !rst && (flush || in_ready);
            if (rst) begin
                exp_q.delete();
                exp_cnt = 0;
                armed   = 1'b1;
            end else if (flush) begin
                exp_q.delete();
            end else begin
                if (in_valid && exp_in_ready(SK, occ_s, out_ready))
                    exp_q.push_back({mem_in, alu_in, rd_in, ctl_in});
                if (occ_s > 0 && !out_ready && exp_cnt < CMAX) exp_cnt++;
            end
        end

        task automatic step(input int n);
            repeat (n) @(posedge clk);
            #1;
        endtask

        task automatic push_beat(input logic [DW-1:0] alu);
            src.push_back({DW'($urandom), alu, RW'($urandom), CW'($urandom)});
        endtask

        task automatic drain(input int budget);
            int k = 0;
            while ((src.size() > 0 || exp_q.size() > 0 || in_valid) && k < budget) begin
                step(1);
                k++;
            end
            check(g, "drain_left", src.size() + exp_q.size(), 0);
        endtask

        initial begin
            rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
            mem_in = '0; alu_in = '0; rd_in = '1; ctl_in = '1;
            step(2);
            rst = 1'b0;
            check(g, "reset_in_ready", in_ready, 1'b1);
            check(g, "reset_out_valid", out_valid, 1'b0);

            // Back-to-back stream with a consumer that never stalls
            for (int i = 1; i <= 8; i++) push_beat(DW'(i));
            drain(40);
            check(g, "stream_stall", stall, 0);

            // Backpressure: hold out_ready low while three beats are offered
            out_ready = 1'b0;
            push_beat(32'h11); push_beat(32'h22); push_beat(32'h33);
            step(6);
            check(g, "bp_in_ready", in_ready, 1'b0);
            check(g, "bp_stall", stall, exp_cnt);
            out_ready = 1'b1;
            drain(40);

            // Flush while full with a beat on the input
            out_ready = 1'b0;
            push_beat(32'h44); push_beat(32'h55);
            step(4);
            push_beat(32'h66);
            step(1);
            flush = 1'b1;
            step(1);
            flush = 1'b0;
            check(g, "flush_out_valid", out_valid, 1'b0);
            check(g, "flush_ctl_rd", {ctl_out, rd_out}, '0);
            check(g, "flush_in_ready", in_ready, 1'b1);
            out_ready = 1'b1;
            drain(40);

            // Long stall: the counter must stop at its maximum
            out_ready = 1'b0;
            push_beat(32'h77);
            step(22);
            check(g, "sat_stall", stall, exp_cnt);
            out_ready = 1'b1;
            drain(40);

            // Reset while holding beats
            out_ready = 1'b0;
            push_beat(32'h81); push_beat(32'h82); push_beat(32'h83);
            step(5);
            rst = 1'b1;
            src.delete();
            step(1);
            rst = 1'b0;
            check(g, "midrst_outs", {out_valid, mem_out, alu_out, rd_out, ctl_out, stall}, '0);
            check(g, "midrst_in_ready", in_ready, 1'b1);

            // Full stage: in_ready against out_ready changed within one cycle
            push_beat(32'h91); push_beat(32'h92);
            step(4);
            out_ready = 1'b1;
            #1 check(g, "comb_ready_hi", in_ready, exp_in_ready(SK, exp_q.size(), 1'b1));
            out_ready = 1'b0;
            #1 check(g, "comb_ready_lo", in_ready, exp_in_ready(SK, exp_q.size(), 1'b0));
            out_ready = 1'b1;
            drain(40);

            // Randomized traffic with gaps, stalls and occasional flushes
            gap_pct = 30;
            for (int c = 0; c < 300; c++) begin
                out_ready = 1'($urandom_range(1));
                flush     = ($urandom_range(31) == 0);
                if ($urandom_range(2) == 0) push_beat($urandom);
                step(1);
            end
            flush = 1'b0;
            out_ready = 1'b1;
            gap_pct = 0;
            drain(200);
            done = 1'b1;
        end
    end

    initial begin
        for (int k = 0; k < 20000; k++) begin
            if (lane[0].done && lane[1].done) break;
            @(posedge clk);
        end
        check(2, "lanes_done", {lane[0].done, lane[1].done}, 2'b11);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
